// File: rtl/plusarg_watchdog_pkg.sv
// Shared types and constants for the plusarg watchdog.
package plusarg_watchdog_pkg;

  // Default width of the cycle limit and the tick counter.
  localparam int WD_WIDTH_DEFAULT = 32;

  // Prescaler counter width; covers PRESCALE values up to 65535.
  localparam int PRESCALE_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_EXPIRED  = 2'd2,
    ST_FINISHED = 2'd3
  } wd_state_e;

endpackage

// File: rtl/plusarg_watchdog_prescaler.sv
// Tick generator: counts 0..PRESCALE-1 while enabled and emits a tick on the
// edge where the count wraps. PRESCALE=1 gives a tick on every enabled edge.
module plusarg_watchdog_prescaler
  import plusarg_watchdog_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam logic [PRESCALE_CNT_W-1:0] LAST = PRESCALE_CNT_W'(PRESCALE - 1);

  logic [PRESCALE_CNT_W-1:0] r_cnt;
  logic                      w_wrap;

  assign w_wrap = (r_cnt == LAST);
  // A clear (arming or kick) restarts the phase, so it also suppresses the tick.
  assign tick   = enable && !clear && w_wrap;

  // Phase counter: cleared on arm/kick, advances only while enabled.
  // NOTE: every register in this design has an async reset; they are small
  // control flops, not memory arrays, so there is no reason to leave any out.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= w_wrap ? '0 : r_cnt + PRESCALE_CNT_W'(1);
    end
  end

endmodule

// File: rtl/plusarg_watchdog.sv
// Simulation watchdog armed by a start pulse with a plusarg-supplied limit.
// Counts prescaled ticks in RUN; reaching the limit is a sticky timeout,
// done_in is a sticky success. Both terminal states hold until reset.
// Optional feature: define PLUSARG_WATCHDOG_KICK_EN to let the kick input
// restart the count while running; otherwise kick is ignored.
module plusarg_watchdog
  import plusarg_watchdog_pkg::*;
#(
  parameter int WIDTH    = WD_WIDTH_DEFAULT,
  parameter int PRESCALE = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] limit,
  input  logic             start,
  input  logic             kick,
  input  logic             done_in,
  output logic             running,
  output logic             expired,
  output logic             finished,
  output logic [WIDTH-1:0] count
);

  wd_state_e        r_state;
  logic [WIDTH-1:0] r_limit_q;
  logic [WIDTH-1:0] r_count;

  logic             w_kick;
  logic             w_arm;
  logic             w_restart;
  logic             w_clear;
  logic             w_tick;
  logic [WIDTH-1:0] w_count_inc;

`ifdef PLUSARG_WATCHDOG_KICK_EN
  assign w_kick = kick;
`else
  logic w_kick_unused;
  assign w_kick_unused = kick;
  assign w_kick        = 1'b0;
`endif

  assign w_arm       = (r_state == ST_IDLE) && start && (limit != '0);
  // done_in outranks kick, so a kick on the finishing edge changes nothing.
  assign w_restart   = (r_state == ST_RUN) && w_kick && !done_in;
  assign w_clear     = w_arm || w_restart;
  assign w_count_inc = r_count + WIDTH'(1);

  plusarg_watchdog_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (w_clear),
    .enable  (r_state == ST_RUN),
    .tick    (w_tick)
  );

  // FSM plus the held limit and the tick count; terminal states freeze all.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, regardless of statement order within the block.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_limit_q <= '0;
      r_count   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_arm) begin
            r_limit_q <= limit;
            r_count   <= '0;
            r_state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (done_in) begin
            r_state <= ST_FINISHED;
          end else if (w_restart) begin
            r_count <= '0;
          end else if (w_tick) begin
            r_count <= w_count_inc;
            // Expiry at equality keeps count from ever wrapping.
            if (w_count_inc == r_limit_q) begin
              r_state <= ST_EXPIRED;
            end
          end
        end
        default: begin
          r_state <= r_state;
        end
      endcase
    end
  end

  // Outputs are pure decodes of registered state, free of input paths.
  assign running  = (r_state == ST_RUN);
  assign expired  = (r_state == ST_EXPIRED);
  assign finished = (r_state == ST_FINISHED);
  assign count    = r_count;

endmodule

// File: tb/tb_plusarg_watchdog.sv
// Bench for plusarg_watchdog: a PRESCALE=1 and a PRESCALE=4 instance share
// all inputs. Directed table, corner-case sequences, then random stimulus
// against an elapsed-cycle reference model.
module tb_plusarg_watchdog;

  localparam int W = 8;

`ifdef PLUSARG_WATCHDOG_KICK_EN
  localparam bit KICK_EN = 1'b1;
`else
  localparam bit KICK_EN = 1'b0;
`endif

  logic         clock;
  logic         reset_n;
  logic [W-1:0] limit;
  logic         start;
  logic         kick;
  logic         done_in;

  logic         running1, expired1, finished1;
  logic [W-1:0] count1;
  logic         running4, expired4, finished4;
  logic [W-1:0] count4;

  int total = 0;
  int bad   = 0;

  plusarg_watchdog #(.WIDTH(W), .PRESCALE(1)) u_dut1 (
    .clock    (clock),
    .reset_n  (reset_n),
    .limit    (limit),
    .start    (start),
    .kick     (kick),
    .done_in  (done_in),
    .running  (running1),
    .expired  (expired1),
    .finished (finished1),
    .count    (count1)
  );

  plusarg_watchdog #(.WIDTH(W), .PRESCALE(4)) u_dut4 (
    .clock    (clock),
    .reset_n  (reset_n),
    .limit    (limit),
    .start    (start),
    .kick     (kick),
    .done_in  (done_in),
    .running  (running4),
    .expired  (expired4),
    .finished (finished4),
    .count    (count4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // {running, expired, finished, count}
  logic [W+2:0] obs1, obs4;
  assign obs1 = {running1, expired1, finished1, count1};
  assign obs4 = {running4, expired4, finished4, count4};

  function automatic logic [W+2:0] mk(bit r, bit e, bit f, int c);
    return {r, e, f, W'(c)};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One rising edge, then settle before sampling.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Reset pulse placed between edges; leaves all pulse inputs low.
  task automatic do_reset();
    start   = 1'b0;
    kick    = 1'b0;
    done_in = 1'b0;
    reset_n = 1'b0;
    #3;
    reset_n = 1'b1;
  endtask

  // ---------------- reference model ----------------
  // Tracks elapsed RUN cycles since arming/kick; count = elapsed / PRESCALE.
  bit m_act [2];
  bit m_exp [2];
  bit m_fin [2];
  int m_el  [2];
  int m_lim [2];
  int m_ps  [2] = '{1, 4};

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_exp[i] = 0; m_fin[i] = 0; m_el[i] = 0; m_lim[i] = 0;
    end
  endtask

  task automatic model_edge(bit st, int lim, bit kk, bit dn);
    for (int i = 0; i < 2; i++) begin
      if (!m_act[i] && !m_exp[i] && !m_fin[i]) begin
        if (st && lim != 0) begin
          m_act[i] = 1; m_lim[i] = lim; m_el[i] = 0;
        end
      end else if (m_act[i]) begin
        if (dn) begin
          m_fin[i] = 1; m_act[i] = 0;
        end else if (KICK_EN && kk) begin
          m_el[i] = 0;
        end else begin
          m_el[i]++;
          if (m_el[i] / m_ps[i] == m_lim[i]) begin
            m_exp[i] = 1; m_act[i] = 0;
          end
        end
      end
    end
  endtask

  function automatic logic [W+2:0] model_obs(int i);
    return {m_act[i], m_exp[i], m_fin[i], W'(m_el[i] / m_ps[i])};
  endfunction

  // ---------------- directed table ----------------
  typedef struct {
    bit           rst;
    bit           st;
    logic [W-1:0] lim;
    bit           dn;
    logic [W+2:0] exp_o;
  } vec_t;

  vec_t vecs[$];

  initial begin
    reset_n = 1'b0;
    limit   = '0;
    start   = 1'b0;
    kick    = 1'b0;
    done_in = 1'b0;
    #2;
    check("reset_state", 32'(obs1), 32'(mk(0, 0, 0, 0)));
    check("reset_state_p4", 32'(obs4), 32'(mk(0, 0, 0, 0)));
    reset_n = 1'b1;
    #2;

    // Absolute timeout with limit=5; start/limit changes ignored in RUN.
    vecs.push_back('{1, 0, 8'd5, 1, mk(0, 0, 0, 0)}); // done in IDLE ignored
    vecs.push_back('{0, 1, 8'd5, 0, mk(1, 0, 0, 0)}); // edge 0: arm
    vecs.push_back('{0, 0, 8'd5, 0, mk(1, 0, 0, 1)});
    vecs.push_back('{0, 1, 8'd5, 0, mk(1, 0, 0, 2)}); // restart ignored
    vecs.push_back('{0, 0, 8'd2, 0, mk(1, 0, 0, 3)}); // limit change ignored
    vecs.push_back('{0, 0, 8'd5, 0, mk(1, 0, 0, 4)});
    vecs.push_back('{0, 0, 8'd5, 0, mk(0, 1, 0, 5)}); // edge 5: expired
    vecs.push_back('{0, 1, 8'd5, 1, mk(0, 1, 0, 5)}); // terminal
    vecs.push_back('{0, 0, 8'd5, 0, mk(0, 1, 0, 5)});
    // done_in on the expiry edge wins.
    vecs.push_back('{1, 1, 8'd5, 0, mk(1, 0, 0, 0)});
    vecs.push_back('{0, 0, 8'd5, 0, mk(1, 0, 0, 1)});
    vecs.push_back('{0, 0, 8'd5, 0, mk(1, 0, 0, 2)});
    vecs.push_back('{0, 0, 8'd5, 0, mk(1, 0, 0, 3)});
    vecs.push_back('{0, 0, 8'd5, 0, mk(1, 0, 0, 4)});
    vecs.push_back('{0, 0, 8'd5, 1, mk(0, 0, 1, 4)}); // edge 5: finished
    vecs.push_back('{0, 1, 8'd5, 0, mk(0, 0, 1, 4)});
    vecs.push_back('{0, 0, 8'd5, 1, mk(0, 0, 1, 4)});
    // limit=0 start keeps IDLE.
    vecs.push_back('{1, 1, 8'd0, 0, mk(0, 0, 0, 0)});

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      start   = vecs[i].st;
      limit   = vecs[i].lim;
      done_in = vecs[i].dn;
      step();
      check($sformatf("table[%0d]", i), 32'(obs1), 32'(vecs[i].exp_o));
    end
    start = 1'b0; done_in = 1'b0;

    // PRESCALE=4, limit=3: count steps at edges 4, 8, 12; expiry at 12.
    do_reset();
    limit = 8'd3; start = 1'b1;
    step();
    start = 1'b0;
    for (int e = 1; e <= 14; e++) begin
      step();
      check($sformatf("p4_count_e%0d", e), 32'(count4), (e / 4 > 3) ? 32'd3 : 32'(e / 4));
      check($sformatf("p4_expired_e%0d", e), 32'(expired4), 32'(e >= 12));
    end

    // limit=0 start pulse: both instances stay idle for 100 cycles.
    do_reset();
    limit = 8'd0; start = 1'b1;
    step();
    start = 1'b0;
    for (int e = 1; e <= 100; e++) begin
      step();
      check("limit0_idle", {28'd0, running1, expired1, running4, expired4}, 32'd0);
    end

    // Kick at edges 3 and 6 with limit=4.
    do_reset();
    limit = 8'd4; start = 1'b1;
    step();
    start = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      kick = (e == 3 || e == 6);
      step();
      check($sformatf("kick_expired_e%0d", e), 32'(expired1),
            32'(KICK_EN ? (e >= 10) : (e >= 4)));
    end
    kick = 1'b0;

    // Maximum limit: expires exactly at count 255, no wrap.
    do_reset();
    limit = 8'hFF; start = 1'b1;
    step();
    start = 1'b0;
    repeat (254) step();
    check("maxlim_before", 32'(obs1), 32'(mk(1, 0, 0, 254)));
    step();
    check("maxlim_at", 32'(obs1), 32'(mk(0, 1, 0, 255)));
    step();
    check("maxlim_hold", 32'(obs1), 32'(mk(0, 1, 0, 255)));

    // Async reset mid-RUN, then a fresh full-length run.
    do_reset();
    limit = 8'd5; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    check("midrun_count", 32'(obs1), 32'(mk(1, 0, 0, 2)));
    reset_n = 1'b0;
    #1;
    check("async_reset_p1", 32'(obs1), 32'(mk(0, 0, 0, 0)));
    check("async_reset_p4", 32'(obs4), 32'(mk(0, 0, 0, 0)));
    #1;
    reset_n = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      step();
      check($sformatf("rerun_e%0d", e), 32'(obs1),
            32'((e >= 5) ? mk(0, 1, 0, 5) : mk(1, 0, 0, e)));
    end

    // Random stimulus against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      bit st, kk, dn;
      int lim;
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
        model_reset();
      end
      st  = ($urandom_range(0, 9) == 0);
      kk  = ($urandom_range(0, 11) == 0);
      dn  = ($urandom_range(0, 59) == 0);
      lim = $urandom_range(0, 6);
      start = st; kick = kk; done_in = dn; limit = W'(lim);
      model_edge(st, lim, kk, dn);
      step();
      check("rand_p1", 32'(obs1), 32'(model_obs(0)));
      check("rand_p4", 32'(obs4), 32'(model_obs(1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/plusarg_watchdog.md
PLUSARG_WATCHDOG -- requirements
Module: plusarg_watchdog

Interface
REQ-001 Parameter WIDTH, default 32: width of the cycle limit and the tick counter.
REQ-002 Parameter PRESCALE, default 1: clock cycles per counted tick; legal range 1..65535.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 limit  input  WIDTH  timeout in ticks, driven by a plusarg_reader instance; 0 = watchdog disabled; quasi-static.
REQ-006 start  input  1  one-cycle pulse that arms the watchdog.
REQ-007 kick  input  1  heartbeat pulse that restarts the count (only when feature enabled, see Configuration).
REQ-008 done_in  input  1  test-success indication from the harness.
REQ-009 running  output  1  high while in state RUN.
REQ-010 expired  output  1  sticky timeout flag, high in state EXPIRED.
REQ-011 finished  output  1  sticky success flag, high in state FINISHED.
REQ-012 count  output  WIDTH  current tick count.

Function
REQ-013 States: IDLE, RUN, EXPIRED, FINISHED; outputs are registered and decoded from state and count only.
REQ-014 IDLE: if start=1 and limit!=0 at an edge, then limit_q<=limit, count<=0, prescaler<=0, next state RUN; if start=1 and limit==0, remain in IDLE.
REQ-015 RUN: the prescaler counts 0..PRESCALE-1 and wraps; a tick occurs on the edge where it wraps; PRESCALE=1 yields a tick on every edge.
REQ-016 RUN: on a tick, count<=count+1; if count+1==limit_q, next state EXPIRED; with PRESCALE=1, expired rises at edge k+limit_q after start is sampled at edge k.
REQ-017 RUN: done_in=1 moves to FINISHED at that edge; done_in wins over a simultaneous expiry.
REQ-018 RUN: start is ignored; limit changes are ignored because limit_q is held.
REQ-019 EXPIRED and FINISHED are terminal until reset; count freezes; start, kick and done_in are ignored.
REQ-020 count never wraps because limit_q is at most 2^WIDTH-1 and expiry occurs at equality.
REQ-021 done_in in IDLE is ignored.

Reset
REQ-022 Asserting reset_n=0 forces, asynchronously: state=IDLE, count=0, prescaler=0, limit_q=0, running=0, expired=0, finished=0.
REQ-023 Reset mid-RUN aborts with no residual state; the next start restarts from count=0.
REQ-024 Deassertion is assumed synchronised by the harness; the first edge after deassertion may sample start.

Configuration
REQ-025 With macro PLUSARG_WATCHDOG_KICK_EN defined: kick=1 in RUN sets count<=0 and prescaler<=0 at that edge; kick wins over a simultaneous expiry; done_in wins over kick.
REQ-026 With PLUSARG_WATCHDOG_KICK_EN undefined: the kick port exists but is ignored, and the timeout is absolute from start.

Structure
REQ-027 Package plusarg_watchdog_pkg holds the state enum typedef (IDLE, RUN, EXPIRED, FINISHED) and the default WIDTH constant.
REQ-028 Sub-module plusarg_watchdog_prescaler (parameter PRESCALE; inputs clock, reset_n, clear, enable; output tick) implements the tick generator.
REQ-029 Top-level RTL contains the FSM, the limit_q register and the count register.

Verification
REQ-030 PRESCALE=1, limit=5, start pulse at edge 0, no kick or done -> running=1 at edges 1-4; expired=1 from edge 5 and stays high; count=5.
REQ-031 PRESCALE=4, limit=3, start at edge 0 -> expired rises at edge 12; count steps 1,2,3 at edges 4, 8, 12.
REQ-032 limit=0, start pulse -> stays IDLE; running=0, expired=0 for 100 cycles.
REQ-033 PRESCALE=1, limit=5, start at edge 0, done_in at edge 5 (same edge as expiry) -> finished=1, expired=0.
REQ-034 KICK_EN defined, limit=4, kick at edges 3 and 6 -> expired at edge 10; with KICK_EN undefined, same stimulus -> expired at edge 4.
REQ-035 reset_n pulsed low mid-RUN (count=2) -> all outputs 0 immediately, without waiting for an edge; a new start then expires after a full limit.
